// File: rtl/surf_simplified_pkg.sv
// Shared constants and helpers for the simplified SURF Hessian multiplier path.
// Default operand/product widths match one DSP48 slice.
package surf_simplified_pkg;

    localparam int MUL_A_W = 16;
    localparam int MUL_B_W = 11;
    localparam int MUL_P_W = 16;

    // Never returns less than 1, so a tag port always exists.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic logic [MUL_P_W-1:0] mul_trunc(input logic [MUL_A_W-1:0] a,
                                                     input logic [MUL_B_W-1:0] b);
        logic signed [MUL_A_W+MUL_B_W:0] full;
        full = $signed(a) * $signed({1'b0, b});
        return MUL_P_W'(full);
    endfunction

endpackage

// File: rtl/surf_simplified_mul_core.sv
// Combinational signed x unsigned multiply, truncated to the low P_WIDTH bits.
// Sits between the operand and product registers so it maps onto one DSP block.
module surf_simplified_mul_core
    import surf_simplified_pkg::*;
#(
    parameter int A_WIDTH = MUL_A_W,
    parameter int B_WIDTH = MUL_B_W,
    parameter int P_WIDTH = MUL_P_W
) (
    input  logic [A_WIDTH-1:0] a,
    input  logic [B_WIDTH-1:0] b,
    output logic [P_WIDTH-1:0] p
);

    generate
        if (A_WIDTH == MUL_A_W && B_WIDTH == MUL_B_W && P_WIDTH == MUL_P_W) begin : g_pkg
            assign p = mul_trunc(a, b);
        end else begin : g_generic
            logic signed [A_WIDTH+B_WIDTH:0] full;
            assign full = $signed(a) * $signed({1'b0, b});
            assign p    = P_WIDTH'(full);
        end
    endgenerate

endmodule

// File: rtl/surf_simplified_mul_arbiter.sv
// Round-robin shares one truncating multiplier among NUM_REQ requesters through
// a two-stage pipeline (operands, product) with a backpressured result channel.
module surf_simplified_mul_arbiter
    import surf_simplified_pkg::*;
#(
    parameter int  NUM_REQ  = 3,
    parameter int  A_WIDTH  = MUL_A_W,
    parameter int  B_WIDTH  = MUL_B_W,
    parameter int  P_WIDTH  = MUL_P_W,
    localparam int ID_WIDTH = clog2(NUM_REQ)
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [P_WIDTH-1:0]         res_p,
    output logic [ID_WIDTH-1:0]        res_id,
    output logic                       busy
);

    logic [A_WIDTH-1:0]  a_arr [NUM_REQ];
    logic [B_WIDTH-1:0]  b_arr [NUM_REQ];

    logic [ID_WIDTH-1:0] rr_reg, rr_next;
    logic                grant_v;
    logic [ID_WIDTH-1:0] grant_idx;
    logic                accept;

    logic                s1_v_reg, s2_v_reg;
    logic [A_WIDTH-1:0]  s1_a_reg;
    logic [B_WIDTH-1:0]  s1_b_reg;
    logic [ID_WIDTH-1:0] s1_id_reg, s2_id_reg;
    logic [P_WIDTH-1:0]  s2_p_reg;
    logic [P_WIDTH-1:0]  prod;
    logic                s1_en, s2_en;

    assign s2_en = !s2_v_reg || res_ready;
    assign s1_en = !s1_v_reg || s2_en;

    // Ready is held low during reset so nothing appears accepted while flushing.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign a_arr[gi]     = req_a[gi*A_WIDTH +: A_WIDTH];
            assign b_arr[gi]     = req_b[gi*B_WIDTH +: B_WIDTH];
            assign req_ready[gi] = ap_rst_n && s1_en && grant_v && (grant_idx == ID_WIDTH'(gi));
        end
    endgenerate

    // First valid requester at or above the pointer, wrapping at NUM_REQ.
    always_comb begin
        int idx;
        idx       = 0;
        grant_v   = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_reg) + k) % NUM_REQ;
            if (!grant_v && req_valid[idx]) begin
                grant_v   = 1'b1;
                grant_idx = ID_WIDTH'(idx);
            end
        end
    end

    assign accept = |(req_valid & req_ready);

    always_comb begin
        rr_next = rr_reg;
        if (accept) begin
            rr_next = (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    surf_simplified_mul_core #(
        .A_WIDTH (A_WIDTH),
        .B_WIDTH (B_WIDTH),
        .P_WIDTH (P_WIDTH)
    ) u_core (
        .a (s1_a_reg),
        .b (s1_b_reg),
        .p (prod)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rr_reg    <= '0;
            s1_v_reg  <= 1'b0;
            s1_a_reg  <= '0;
            s1_b_reg  <= '0;
            s1_id_reg <= '0;
            s2_v_reg  <= 1'b0;
            s2_p_reg  <= '0;
            s2_id_reg <= '0;
        end else begin
            rr_reg <= rr_next;
            if (s1_en) begin
                s1_v_reg <= accept;
                if (accept) begin
                    s1_a_reg  <= a_arr[grant_idx];
                    s1_b_reg  <= b_arr[grant_idx];
                    s1_id_reg <= grant_idx;
                end
            end
            if (s2_en) begin
                s2_v_reg <= s1_v_reg;
                if (s1_v_reg) begin
                    s2_p_reg  <= prod;
                    s2_id_reg <= s1_id_reg;
                end
            end
        end
    end

    assign res_valid = s2_v_reg;
    assign res_p     = s2_p_reg;
    assign res_id    = s2_id_reg;
    assign busy      = s1_v_reg || s2_v_reg;

endmodule

// File: tb/tb_surf_simplified_mul_arbiter.sv
// Scoreboard bench: operands are queued per requester together with the
// hand-computed result expected on the shared result channel.
module tb_surf_simplified_mul_arbiter;

    localparam int NR = 3;
    localparam int AW = 16;
    localparam int BW = 11;
    localparam int PW = 16;
    localparam int IW = 2;

    logic              ap_clk = 1'b0;
    logic              ap_rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*AW-1:0]  req_a;
    logic [NR*BW-1:0]  req_b;
    logic              res_valid;
    logic              res_ready;
    logic [PW-1:0]     res_p;
    logic [IW-1:0]     res_id;
    logic              busy;

    logic [AW+BW-1:0]  pend [NR][$];
    logic [IW+PW-1:0]  exp_q[$];

    int checks_total = 0;
    int checks_pass  = 0;

    surf_simplified_mul_arbiter #(
        .NUM_REQ (NR),
        .A_WIDTH (AW),
        .B_WIDTH (BW),
        .P_WIDTH (PW)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_p     (res_p),
        .res_id    (res_id),
        .busy      (busy)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks_total++;
        if (act === req) checks_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #2;
    endtask

    task automatic push_op(input int id, input logic [AW-1:0] a, input logic [BW-1:0] b,
                           input logic [PW-1:0] p);
        pend[id].push_back({a, b});
        exp_q.push_back({IW'(id), p});
    endtask

    function automatic bit pend_empty();
        return pend[0].size() == 0 && pend[1].size() == 0 && pend[2].size() == 0;
    endfunction

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !pend_empty() || busy) && n < 60) begin
            tick();
            n++;
        end
        if (n >= 60) begin
            checks_total++;
            $display("FAIL %s: drain timeout, outstanding=%0d required 0", name, exp_q.size());
        end
    endtask

    // Requester driver: holds each operand until it is seen accepted.
    initial begin
        logic [NR-1:0]    acc;
        logic [AW+BW-1:0] tmp;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        forever begin
            @(negedge ap_clk);
            #4;
            acc = req_valid & req_ready;
            @(posedge ap_clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (acc[i]) begin
                    void'(pend[i].pop_front());
                    req_valid[i] = 1'b0;
                end
                if (!req_valid[i] && pend[i].size() > 0) begin
                    tmp = pend[i][0];
                    req_valid[i]        = 1'b1;
                    req_a[i*AW +: AW]   = tmp[AW+BW-1:BW];
                    req_b[i*BW +: BW]   = tmp[BW-1:0];
                end
            end
        end
    end

    // Result monitor.
    initial begin
        logic [IW+PW-1:0] e;
        forever begin
            @(negedge ap_clk);
            if (ap_rst_n && res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    checks_total++;
                    $display("FAIL unexpected_result: got id=%0d p=0x%04h required none", res_id, res_p);
                end else begin
                    e = exp_q.pop_front();
                    $display("result id=%0d p=0x%04h (expected id=%0d p=0x%04h)",
                             res_id, res_p, e[IW+PW-1:PW], e[PW-1:0]);
                    chk("result", {14'd0, res_id, res_p}, {14'd0, e});
                end
            end
        end
    end

    initial begin
        int n;
        bit found;
        ap_rst_n  = 1'b0;
        res_ready = 1'b0;
        tick();
        tick();
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_res_p", res_p, 0);
        chk("rst_res_id", res_id, 0);
        ap_rst_n  = 1'b1;
        res_ready = 1'b1;
        tick();

        // Single request and latency.
        push_op(0, 16'hFFFD, 11'd5, 16'hFFF1);
        n = 0;
        found = 0;
        while (!found && n < 20) begin
            @(negedge ap_clk);
            #4;
            if (req_valid[0] && req_ready[0]) found = 1;
            n++;
        end
        chk("single_accept_seen", found, 1);
        chk("lat_before_accept", res_valid, 0);
        @(posedge ap_clk);
        #4;
        chk("lat_after_edge_t", res_valid, 0);
        @(posedge ap_clk);
        #4;
        chk("lat_after_edge_t1", res_valid, 1);
        tick();
        drain("single");

        // Truncation; rr=1 here so req1 then req2, leaving rr=0.
        push_op(1, 16'h7FFF, 11'd2, 16'hFFFE);
        push_op(2, 16'h8000, 11'h7FF, 16'h8000);
        drain("trunc");

        // Fairness: all three continuously valid.
        push_op(0, 16'd10,    11'd3,    16'h001E);
        push_op(1, 16'd100,   11'd7,    16'h02BC);
        push_op(2, 16'hFFFE,  11'h7FF,  16'hF002);
        push_op(0, 16'hFFFF,  11'd1,    16'hFFFF);
        push_op(1, 16'h1234,  11'h010,  16'h2340);
        push_op(2, 16'h0101,  11'h100,  16'h0100);
        n = 0;
        do begin
            @(negedge ap_clk);
            n++;
        end while (!res_valid && n < 20);
        for (int k = 0; k < 5; k++) begin
            @(negedge ap_clk);
            chk("throughput", res_valid, 1);
        end
        tick();
        drain("fair");

        // Backpressure: four ops from req1 with res_ready low for five cycles.
        res_ready = 1'b0;
        push_op(1, 16'd1,     11'd1,    16'h0001);
        push_op(1, 16'd2,     11'd3,    16'h0006);
        push_op(1, 16'hFFFC,  11'd4,    16'hFFF0);
        push_op(1, 16'h0400,  11'h040,  16'h0000);
        tick();
        tick();
        tick();
        tick();
        chk("bp_valid", res_valid, 1);
        chk("bp_p_held", res_p, 16'h0001);
        chk("bp_id", res_id, 1);
        chk("bp_ready_low", req_ready, 0);
        chk("bp_busy", busy, 1);
        tick();
        chk("bp_p_held2", res_p, 16'h0001);
        chk("bp_ready_low2", req_ready, 0);
        res_ready = 1'b1;
        drain("backpressure");

        // Reset with both stages full; rr=2 beforehand.
        res_ready = 1'b0;
        pend[1].push_back({16'd7, 11'd7});
        pend[1].push_back({16'd9, 11'd9});
        tick();
        tick();
        tick();
        tick();
        chk("pre_rst_busy", busy, 1);
        ap_rst_n = 1'b0;
        #1;
        chk("async_rst_res_valid", res_valid, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_req_ready", req_ready, 0);
        for (int i = 0; i < NR; i++) pend[i].delete();
        req_valid = '0;
        tick();
        tick();
        ap_rst_n  = 1'b1;
        res_ready = 1'b1;
        tick();
        push_op(1, 16'd3,     11'd3,    16'h0009);
        push_op(2, 16'hFFFF,  11'h7FF,  16'hF801);
        drain("post_reset");

        // Pointer wrap: lone req2, then req1+req2 must grant req1 first.
        push_op(2, 16'd5,     11'd5,    16'h0019);
        drain("wrap_a");
        push_op(1, 16'hFFFB,  11'd2,    16'hFFF6);
        push_op(2, 16'h4000,  11'd4,    16'h0000);
        drain("wrap_b");

        $display("%0d/%0d checks passed", checks_pass, checks_total);
        $finish;
    end

endmodule
